muldiv_sequencer: RTL

- Multi-cycle controller and iterative datapath for the ALU's MUL (ALUcont 4'h3) and DIV (ALUcont 4'h4) operations.
- Accepts one operation at a time and runs a WIDTH-step shift-add multiply or restoring divide.
- Writes the results to HI/LO registers.
- Drives busy so the pipeline control can stall issue while a long operation is in flight.

---
 rtl/muldiv_sequencer.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle MUL/DIV unit with HI/LO result registers.
// Runs a WIDTH-step shift-add multiply or a restoring divide, one bit per
// clock, and raises busy so issue can stall while an op is in flight.
// Optional macro MULDIV_SIGNED_EN: two's-complement operands (sign
// fix-up happens on the commit edge, so latency is unchanged).
module muldiv_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       ALUcont,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam logic [3:0] OP_MUL = 4'h3;
  localparam logic [3:0] OP_DIV = 4'h4;

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     cnt;
  logic [2*WIDTH-1:0]   acc;    // MUL: {partial product, multiplier}; DIV: {rem, dividend/quotient}
  logic [WIDTH-1:0]     opnd;   // multiplicand or divisor magnitude
  logic                 is_div;

  logic                 accept, div0, last;
  logic [WIDTH-1:0]     a_mag, b_mag;

  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_nxt;
  logic [WIDTH:0]       rem_sh;
  logic [WIDTH-1:0]     rem_diff, rem_nxt;
  logic                 rem_ge;
  logic [2*WIDTH-1:0]   div_nxt;
  logic [2*WIDTH-1:0]   step;
  logic [WIDTH-1:0]     res_hi, res_lo;

`ifdef MULDIV_SIGNED_EN
  logic                 neg_q;  // product / quotient must be negated
  logic                 neg_r;  // remainder must be negated (dividend sign)
  logic [2*WIDTH-1:0]   prod_fix;
`endif

  assign accept = (state == IDLE) && start && !flush &&
                  ((ALUcont == OP_MUL) || (ALUcont == OP_DIV));
  assign div0   = accept && (ALUcont == OP_DIV) && (op_b == '0);
  assign last   = (state == CALC) && (cnt == CNT_W'(WIDTH-1));

`ifdef MULDIV_SIGNED_EN
  assign a_mag = op_a[WIDTH-1] ? (~op_a + 1'b1) : op_a;
  assign b_mag = op_b[WIDTH-1] ? (~op_b + 1'b1) : op_b;
`else
  assign a_mag = op_a;
  assign b_mag = op_b;
`endif

  // One iteration of each algorithm; the active one is selected by is_div.
  always_comb begin
    // shift-add multiply: add multiplicand to upper half if LSB set, shift right with carry
    mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
    mul_nxt = acc[0] ? {mul_sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};
    // restoring divide: shift {rem, dq} left, trial-subtract divisor
    rem_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    rem_ge   = (rem_sh >= {1'b0, opnd});
    rem_diff = rem_sh[WIDTH-1:0] - opnd;
    rem_nxt  = rem_ge ? rem_diff : rem_sh[WIDTH-1:0];
    div_nxt  = {rem_nxt, acc[WIDTH-2:0], rem_ge};
    step     = is_div ? div_nxt : mul_nxt;
    // commit values, with sign fix-up folded in when enabled
`ifdef MULDIV_SIGNED_EN
    prod_fix = neg_q ? (~step + 1'b1) : step;
    if (is_div) begin
      res_hi = neg_r ? (~step[2*WIDTH-1:WIDTH] + 1'b1) : step[2*WIDTH-1:WIDTH];
      res_lo = neg_q ? (~step[WIDTH-1:0] + 1'b1) : step[WIDTH-1:0];
    end else begin
      res_hi = prod_fix[2*WIDTH-1:WIDTH];
      res_lo = prod_fix[WIDTH-1:0];
    end
`else
    res_hi = step[2*WIDTH-1:WIDTH];
    res_lo = step[WIDTH-1:0];
`endif
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and status outputs; flush wins over everything
  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    done      = 1'b0;
    case (state)
      IDLE: if (accept) state_nxt = div0 ? DONE : CALC;
      CALC: begin
        if (flush)     state_nxt = IDLE;
        else if (last) state_nxt = DONE;
      end
      DONE: begin
        done      = !flush;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: operand latch on accept, one step per CALC edge, commit on last step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      acc         <= '0;
      opnd        <= '0;
      is_div      <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
`ifdef MULDIV_SIGNED_EN
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
`endif
    end else if (accept) begin
      cnt    <= '0;
      is_div <= (ALUcont == OP_DIV);
      if (ALUcont == OP_DIV) begin
        opnd <= b_mag;
        acc  <= {{WIDTH{1'b0}}, a_mag};
      end else begin
        opnd <= a_mag;
        acc  <= {{WIDTH{1'b0}}, b_mag};
      end
`ifdef MULDIV_SIGNED_EN
      neg_q <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
      neg_r <= op_a[WIDTH-1];
`endif
      if (div0) begin
        hi          <= op_a;
        lo          <= '1;
        div_by_zero <= 1'b1;
      end else begin
        div_by_zero <= 1'b0;
      end
    end else if (state == CALC && !flush) begin
      acc <= step;
      cnt <= cnt + 1'b1;
      if (last) begin
        hi <= res_hi;
        lo <= res_lo;
      end
    end
  end

endmodule
